ac97_frame_gen: RTL
===================

// Module: ac97_frame_gen
// PURPOSE
//  Upstream frame builder for the AC97 serial output shifter: counts BIT_CLK cycles across 256-bit frames.
//  Drives SYNC, accepts one codec command and one stereo PCM sample per frame, builds tag slot 0 and slots 1-4.
//  Pulses so_ld so the shifter loads the new frame on the edge that starts bit 0.
// PARAMETERS
//  SYNC_BITS  16   SYNC high cycles at frame start (1..255)
//  PCM_W      16   PCM sample width (1..20); MSB-justified into 20-bit slot, LSBs zero
// PORTS
//  clk        in   1      AC97 BIT_CLK; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      frame generation enable
//  cmd_valid  in   1      command pending
//  cmd_rw     in   1      1=read, 0=write
//  cmd_addr   in   7      codec register address
//  cmd_wdata  in   16     write data (ignored for reads)
//  cmd_ready  out  1      1-cycle pulse: command accepted
//  pcm_valid  in   1      stereo sample pending
//  pcm_l      in   PCM_W  left sample
//  pcm_r      in   PCM_W  right sample
//  pcm_ready  out  1      1-cycle pulse: sample accepted
//  sync       out  1      AC97 SYNC
//  so_ld      out  1      load strobe to shifter
//  slt0       out  16     tag slot
//  slt1..slt4 out  20     cmd addr, cmd data, PCM L, PCM R
//  frame_start out 1      1-cycle pulse at bit 0 of each frame
// BEHAVIOUR
//  Reset (async, rst=1): cnt=0, all outputs and slot regs 0, last-sample regs 0.
//  cnt: 8-bit, increments each clk while en=1, wraps 255->0; en=0 clears cnt to 0 next edge.
//  sync: registered; 1 in cycles where cnt is 0..SYNC_BITS-1 and en=1, else 0.
//  frame_start=1 when cnt==0 and en=1.
//  Capture at cnt==254 (en=1): sample cmd_valid/pcm_valid and data; pulse cmd_ready/pcm_ready in
//   that cycle if the matching valid is 1. Valid must be held until ready; data sampled same cycle.
//  so_ld=1 exactly when cnt==255 and en=1; slot outputs are registered on the capture edge and
//   stable from cnt==255 until the next capture.
//  slt0: [15]=|[14:11]; [14]=cmd; [13]=cmd&~rw; [12]=pcm tag; [11]=pcm tag; [10:0]=0.
//  slt1={cmd_rw,cmd_addr,12'h0}; slt2 = write ? {cmd_wdata,4'h0} : 20'h0; cmd slots 0 if no cmd.
//  slt3={pcm_l,(20-PCM_W)'0}, slt4 likewise from pcm_r.
//  Simultaneous cmd and pcm: both accepted in the same frame.
//  en falling mid-frame: frame is abandoned, no so_ld, pending valids are not acknowledged;
//   restart begins at cnt=0 with SYNC.
//  Reset mid-frame: immediate return to reset state; accepted-but-unsent data is discarded.
// CONFIGURATION
//  AC97_PCM_REPEAT_EN defined: if pcm_valid=0 at capture, slt3/slt4 repeat the last accepted
//   sample, tags [12:11]=1 (underrun holds level); pcm_ready not pulsed.
//  Not defined: underrun gives slt3=slt4=0 and tags [12:11]=0.
// TESTING
//  rst then en=1, no valids -> sync high 16 cycles every 256; so_ld at cnt 255; slt0=16'h0000.
//  pcm_valid, L=16'h1234, R=16'hABCD -> pcm_ready pulse at cnt 254; slt0=16'h9800, slt3=20'h12340,
//   slt4=20'hABCD0.
//  cmd write addr 7'h02 data 16'h0808 with pcm idle -> slt0=16'hE000, slt1=20'h02000,
//   slt2=20'h08080; read addr 7'h26 -> slt0=16'hC000, slt1=20'hA6000, slt2=0.
//  PCM underrun after sample 16'h1234: without macro slt3=0 and slt0[12]=0; with
//   AC97_PCM_REPEAT_EN slt3=20'h12340 and slt0[12]=1.
//  en dropped at cnt 100 with valids held -> no so_ld or ready pulses; re-enable -> sync from cnt 0
//   and capture at the next cnt 254.
//  rst asserted at cnt 200 -> all outputs 0 asynchronously; after release, first so_ld 256 cycles
//   after en.

Source files
------------

// File: rtl/ac97_frame_gen.sv
// ============================================================================
// Module   : ac97_frame_gen
// Purpose  : AC97 output frame builder. It counts BIT_CLK cycles across
//            256-bit frames and drives SYNC. Once per frame it accepts one
//            codec command and one stereo PCM sample, and builds tag slot 0
//            and slots 1-4. It pulses so_ld so the serial shifter loads the
//            new frame on the edge that starts bit 0.
// Config   : define AC97_PCM_REPEAT_EN to repeat the last accepted sample
//            (tagged valid) when no new PCM sample is pending at capture.
//            Without it, an underrun sends zero slots with the tags cleared.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ac97_frame_gen #(
  parameter int SYNC_BITS = 16,   // SYNC high cycles at frame start (1..255)
  parameter int PCM_W     = 16    // PCM sample width (1..20)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_addr,
  input  logic [15:0]      cmd_wdata,
  output logic             cmd_ready,
  input  logic             pcm_valid,
  input  logic [PCM_W-1:0] pcm_l,
  input  logic [PCM_W-1:0] pcm_r,
  output logic             pcm_ready,
  output logic             sync,
  output logic             so_ld,
  output logic [15:0]      slt0,
  output logic [19:0]      slt1,
  output logic [19:0]      slt2,
  output logic [19:0]      slt3,
  output logic [19:0]      slt4,
  output logic             frame_start
);

  localparam logic [7:0] CAPTURE_CNT = 8'd254;
  localparam logic [7:0] LOAD_CNT    = 8'd255;
  localparam logic [8:0] SYNC_LIMIT  = 9'(SYNC_BITS);

  logic [7:0]  cnt;
  logic        active;
  logic        capture;
  logic [19:0] l_slot;
  logic [19:0] r_slot;
  logic        cmd_tag;
  logic        wr_tag;
  logic        pcm_tag;

  // Frame decodes come straight from the counter register. They are gated
  // by en, so an abandoned frame produces no strobe. They are also gated by
  // rst, so every output drops the moment reset is asserted.
  assign active      = en & ~rst;
  assign capture     = active & (cnt == CAPTURE_CNT);
  assign sync        = active & ({1'b0, cnt} < SYNC_LIMIT);
  assign frame_start = active & (cnt == 8'd0);
  assign so_ld       = active & (cnt == LOAD_CNT);
  assign cmd_ready   = capture & cmd_valid;
  assign pcm_ready   = capture & pcm_valid;

  // Samples are MSB-justified into the 20-bit slot, and the LSBs are zero.
  assign l_slot = 20'(pcm_l) << (20 - PCM_W);
  assign r_slot = 20'(pcm_r) << (20 - PCM_W);

  // Tag bits for the frame being captured.
  assign cmd_tag = cmd_valid;
  assign wr_tag  = cmd_valid & ~cmd_rw;
`ifdef AC97_PCM_REPEAT_EN
  assign pcm_tag = 1'b1;
`else
  assign pcm_tag = pcm_valid;
`endif

  // Bit counter: runs while enabled, wraps 255->0, and parks at 0 when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Slot registers load on the capture edge. They then hold through the
  // load strobe until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slt0 <= '0;
      slt1 <= '0;
      slt2 <= '0;
      slt3 <= '0;
      slt4 <= '0;
    end else if (capture) begin
      slt0 <= {(cmd_tag | wr_tag | pcm_tag), cmd_tag, wr_tag, pcm_tag, pcm_tag, 11'h000};
      slt1 <= cmd_valid ? {cmd_rw, cmd_addr, 12'h000} : 20'h00000;
      slt2 <= wr_tag ? {cmd_wdata, 4'h0} : 20'h00000;
      if (pcm_valid) begin
        slt3 <= l_slot;
        slt4 <= r_slot;
      end else begin
`ifdef AC97_PCM_REPEAT_EN
        // On underrun, slt3/slt4 keep the last accepted sample so the level holds.
        slt3 <= slt3;
        slt4 <= slt4;
`else
        slt3 <= 20'h00000;
        slt4 <= 20'h00000;
`endif
      end
    end
  end

endmodule

`default_nettype wire
